// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: turns pipeline loads/stores into req/ack bus cycles with alignment and timeout faults.
// Optional one-entry posted store buffer is compiled in when DMEM_STORE_BUF_EN is defined.
module dmem_responder #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_oe,
    input  logic        mem_wr,
    input  logic [31:0] ma,
    input  logic [31:0] mwd,
    output logic [31:0] mrd,
    output logic        mrd_valid,
    output logic        mem_stall,
    output logic        mem_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(BUS_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] mrd_q, mrd_d;
    logic        mrd_valid_q, mrd_valid_d;
    logic        done_q, done_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [29:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        stall_s, start_rd_s, start_wr_s;
    logic [29:0] wr_addr_s;
    logic [31:0] wr_data_s;
    logic        store_s, load_s, misaligned_s;
`ifdef DMEM_STORE_BUF_EN
    logic        sb_valid_q, sb_valid_d;
    logic [29:0] sb_addr_q, sb_addr_d;
    logic [31:0] sb_data_q, sb_data_d;
`endif

    assign store_s      = mem_wr;
    assign load_s       = mem_oe & ~mem_wr;
    assign misaligned_s = (ma[1:0] != 2'b00);

    // Next-state and output decode; done_q masks the request the pipeline still holds after completion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mrd_d       = mrd_q;
        mrd_valid_d = 1'b0;
        done_d      = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        stall_s     = 1'b0;
        start_rd_s  = 1'b0;
        start_wr_s  = 1'b0;
        wr_addr_s   = ma[31:2];
        wr_data_s   = mwd;
`ifdef DMEM_STORE_BUF_EN
        sb_valid_d  = sb_valid_q;
        sb_addr_d   = sb_addr_q;
        sb_data_d   = sb_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (done_q) begin
                    stall_s = 1'b0;
                end else if ((store_s || load_s) && misaligned_s) begin
                    stall_s = 1'b1;
                    state_d = FAULT;
                end else if (store_s) begin
`ifdef DMEM_STORE_BUF_EN
                    if (!sb_valid_q) begin
                        sb_valid_d = 1'b1;
                        sb_addr_d  = ma[31:2];
                        sb_data_d  = mwd;
                    end else begin
                        stall_s    = 1'b1;
                        start_wr_s = 1'b1;
                        wr_addr_s  = sb_addr_q;
                        wr_data_s  = sb_data_q;
                    end
`else
                    stall_s    = 1'b1;
                    start_wr_s = 1'b1;
`endif
                end else if (load_s) begin
                    stall_s = 1'b1;
`ifdef DMEM_STORE_BUF_EN
                    if (sb_valid_q && (sb_addr_q == ma[31:2])) begin
                        mrd_d       = sb_data_q;
                        mrd_valid_d = 1'b1;
                        done_d      = 1'b1;
                    end else if (sb_valid_q) begin
                        start_wr_s = 1'b1;
                        wr_addr_s  = sb_addr_q;
                        wr_data_s  = sb_data_q;
                    end else begin
                        start_rd_s = 1'b1;
                    end
`else
                    start_rd_s = 1'b1;
`endif
                end else begin
`ifdef DMEM_STORE_BUF_EN
                    if (sb_valid_q) begin
                        start_wr_s = 1'b1;
                        wr_addr_s  = sb_addr_q;
                        wr_data_s  = sb_data_q;
                    end else begin
                        start_wr_s = 1'b0;
                    end
`else
                    stall_s = 1'b0;
`endif
                end
            end
            RD_WAIT, WR_WAIT: begin
                stall_s = 1'b1;
                if (bus_ack) begin
                    state_d   = IDLE;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    if (state_q == RD_WAIT) begin
                        mrd_d       = bus_rdata;
                        mrd_valid_d = 1'b1;
                        done_d      = 1'b1;
                    end else begin
`ifdef DMEM_STORE_BUF_EN
                        sb_valid_d = 1'b0;
`else
                        done_d     = 1'b1;
`endif
                    end
                end else if (cnt_q == (TIMEOUT_C - 8'd1)) begin
                    state_d   = FAULT;
                    cnt_d     = cnt_q + 8'd1;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
`ifdef DMEM_STORE_BUF_EN
                    sb_valid_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FAULT: begin
                stall_s = 1'b0;
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start_rd_s) begin
            state_d    = RD_WAIT;
            cnt_d      = 8'd0;
            bus_req_d  = 1'b1;
            bus_we_d   = 1'b0;
            bus_addr_d = ma[31:2];
        end else if (start_wr_s) begin
            state_d     = WR_WAIT;
            cnt_d       = 8'd0;
            bus_req_d   = 1'b1;
            bus_we_d    = 1'b1;
            bus_addr_d  = wr_addr_s;
            bus_wdata_d = wr_data_s;
        end else begin
            start_wr_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mrd_q       <= 32'd0;
            mrd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 30'd0;
            bus_wdata_q <= 32'd0;
`ifdef DMEM_STORE_BUF_EN
            sb_valid_q  <= 1'b0;
            sb_addr_q   <= 30'd0;
            sb_data_q   <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mrd_q       <= mrd_d;
            mrd_valid_q <= mrd_valid_d;
            done_q      <= done_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
`ifdef DMEM_STORE_BUF_EN
            sb_valid_q  <= sb_valid_d;
            sb_addr_q   <= sb_addr_d;
            sb_data_q   <= sb_data_d;
`endif
        end
    end

    assign mrd       = mrd_q;
    assign mrd_valid = mrd_valid_q;
    assign mem_stall = stall_s & ~reset;
    assign mem_fault = (state_q == FAULT);
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
endmodule
